sevenseg_scan: RTL
==================

# sevenseg_scan

Time-multiplexed four-digit seven-segment driver that consumes the stopwatch's BCD digit counts and drives the board's shared cathodes, decimal point and anode enables. It scans one digit per refresh tick, snapshots all four digits at the start of each frame so a count rolling over mid-frame never shows a torn value, blanks the leading zero, and places the decimal point at a fixed digit.

## Interface

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot; 1 kHz digit rate at 100 MHz. Legal range is 2 or more.
- DP_DIGIT, 2: index of the digit whose decimal point is lit, giving d3 d2.d1 d0.
- LZ_BLANK, 1: 1 enables leading-zero blanking of digits above DP_DIGIT.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset. Polarity and synchronicity are fixed: low clears all state immediately.
- d0  in  4  BCD digit 0, least significant.
- d1  in  4  BCD digit 1.
- d2  in  4  BCD digit 2.
- d3  in  4  BCD digit 3, most significant.
- en  in  1  display enable; low blanks all digits without stopping the scan.
- Seg  out  8  active-low segments: [0]=a … [6]=g, [7] mirrors decimal.
- decimal  out  1  active-low decimal point.
- an  out  4  active-low one-hot anode enable; an[i] selects digit i.
- frame  out  1  one-cycle pulse on the edge that starts a new frame (snapshot taken).

## Operation

- Divider cnt counts 0 to REFRESH_DIV-1 and wraps. tick = (cnt == REFRESH_DIV-1).
- Digit index idx is 2 bits. On tick, idx advances 0→1→2→3→0; it does not advance otherwise.
- Snapshot: on the tick where idx wraps 3→0, capture d0..d3 into shadow registers s0..s3 and pulse frame for that one cycle. Inputs are not sampled at any other time.
- Decode, using the digit selected by the new idx (for the wrap edge, use the live inputs being captured). Values below are Seg[6:0] written g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = 0111111 (dash, g only)
- Blanking: digit i is blank if en=0, or if LZ_BLANK=1, i > DP_DIGIT, and s_i and every higher shadow digit are 0. For a blank digit, an=1111 and Seg[6:0]=1111111.
- Decimal point: decimal=0 only when idx==DP_DIGIT and the digit slot is not disabled by en. The decimal point stays lit under leading-zero blanking only if DP_DIGIT itself is not blanked. It is never blanked by LZ rule since i > DP_DIGIT. Seg[7]=decimal.
- en is sampled only on tick edges. Outputs hold between ticks.

## Timing

- Reset (asserted): cnt=0, idx=3, s0..s3=0, an=1111, Seg=8'hFF, decimal=1, frame=0.
- After release, the first tick occurs on the REFRESH_DIV-th rising edge. That edge wraps idx 3→0, snapshots, pulses frame, and lights digit 0.
- All outputs are registered and change only on tick edges. frame is high for exactly one cycle, every 4·REFRESH_DIV cycles.
- Latency: an input change is visible at the next frame start, i.e. 1 to 4·REFRESH_DIV cycles later.
- Input change on a non-wrap tick has no effect until the next wrap (no tearing). Input change on the wrap edge is captured.
- en falling: digits go dark on the next tick; scan and frame continue. en rising: the next tick shows the current shadow digit.
- Reset mid-frame: outputs clear asynchronously. Restart follows the post-reset sequence above.

## Test plan

- REFRESH_DIV=4, d=3,2,1,0 (d3..d0 = 0,1,2,3 as d0=3,d1=2,d2=1,d3=0), en=1, release reset:
  - First tick at edge 4: an=1110, Seg[6:0]=0110000.
  - Edge 8: an=1101, Seg[6:0]=0100100.
  - Edge 12: an=1011, decimal=0, Seg[6:0]=1111001.
  - Edge 16: an=1111 (leading-zero blank).
  - frame pulses at edges 4 and 20.
- Change d0 from 3 to 7 at edge 6 (mid-frame): digit 0 still shows 3 at edge 20? No — snapshot at edge 20 captures 7. Digit 0 shows 0110000 until edge 20, then 1111000.
- d=(0,0,0,0), LZ_BLANK=1: digits 0–2 show 0, and digit 2 shows decimal=0. Digit 3 is blank. Set LZ_BLANK=0: digit 3 shows 1000000.
- d2=4'hC: digit 2 shows Seg[6:0]=0111111.
- en=0 for one full frame: an=1111 and decimal=1 on every tick, frame keeps pulsing. Re-enable: the next tick lights the expected digit.
- Assert reset mid-slot: same cycle an=1111, Seg=FF, frame=0. After release, the first tick lights digit 0 after exactly REFRESH_DIV edges.

Source files
------------

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: four-digit time-multiplexed seven-segment driver.
//
// Scans one digit per refresh slot of REFRESH_DIV clock cycles. All four BCD
// inputs are snapshotted together at the start of each frame, so a counter
// rolling over mid-frame never shows a torn value. Leading zeros above the
// decimal-point digit can be blanked. The decimal point sits on digit DP_DIGIT.
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   reset    in   asynchronous active-low reset
//   d0..d3   in   BCD digits, d0 least significant
//   en       in   display enable (low blanks digits, scan keeps running)
//   Seg      out  active-low segments [6:0]=g..a, [7]=decimal point
//   decimal  out  active-low decimal point
//   an       out  active-low one-hot anode enable, an[i] selects digit i
//   frame    out  one-cycle pulse when a new frame starts (snapshot taken)
module sevenseg_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DP_DIGIT    = 2,
  parameter int unsigned LZ_BLANK    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       en,
  output logic [7:0] Seg,
  output logic       decimal,
  output logic [3:0] an,
  output logic       frame
);

  localparam int unsigned   CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [3:0]    r_s [4];

  logic          w_tick;
  logic          w_wrap;
  logic [1:0]    w_idx_nxt;
  logic [3:0]    w_live [4];
  logic [3:0]    w_src [4];
  logic [3:0]    w_dig;
  logic [3:0]    w_hi_zero;
  logic          w_lz;
  logic          w_blank;
  logic          w_dp_n;
  logic [6:0]    w_seg7;
  logic [3:0]    w_an;

  always_comb begin
    w_tick    = (r_cnt == CNT_LAST);
    w_idx_nxt = r_idx + 2'd1;
    w_wrap    = w_tick && (r_idx == 2'd3);

    w_live[0] = d0;
    w_live[1] = d1;
    w_live[2] = d2;
    w_live[3] = d3;

    // On the wrap edge the shadows are being loaded this same edge, so the
    // decode and blanking must look at the live values being captured.
    for (int unsigned i = 0; i < 4; i++) begin
      w_src[i] = w_wrap ? w_live[i] : r_s[i];
    end

    // w_hi_zero[i]: digit i and every more significant digit are zero.
    w_hi_zero[3] = (w_src[3] == 4'd0);
    w_hi_zero[2] = (w_src[3] == 4'd0) && (w_src[2] == 4'd0);
    w_hi_zero[1] = (w_src[3] == 4'd0) && (w_src[2] == 4'd0) && (w_src[1] == 4'd0);
    w_hi_zero[0] = (w_src[3] == 4'd0) && (w_src[2] == 4'd0) && (w_src[1] == 4'd0)
                   && (w_src[0] == 4'd0);

    w_dig = w_src[w_idx_nxt];

    w_seg7 = 7'b0111111;
    case (w_dig)
      4'd0:    w_seg7 = 7'b1000000;
      4'd1:    w_seg7 = 7'b1111001;
      4'd2:    w_seg7 = 7'b0100100;
      4'd3:    w_seg7 = 7'b0110000;
      4'd4:    w_seg7 = 7'b0011001;
      4'd5:    w_seg7 = 7'b0010010;
      4'd6:    w_seg7 = 7'b0000010;
      4'd7:    w_seg7 = 7'b1111000;
      4'd8:    w_seg7 = 7'b0000000;
      4'd9:    w_seg7 = 7'b0010000;
      default: w_seg7 = 7'b0111111;
    endcase

    w_lz    = (LZ_BLANK != 0) && (32'(w_idx_nxt) > DP_DIGIT) && w_hi_zero[w_idx_nxt];
    w_blank = !en || w_lz;
    // LZ blanking only applies above DP_DIGIT, so only en can dark the point.
    w_dp_n  = !(en && (32'(w_idx_nxt) == DP_DIGIT));

    w_an = 4'hF;
    if (!w_blank) begin
      w_an[w_idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= 2'd3;
      r_s     <= '{default: '0};
      an      <= '1;
      Seg     <= '1;
      decimal <= 1'b1;
      frame   <= 1'b0;
    end else begin
      frame <= w_wrap;
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) begin
        r_idx   <= w_idx_nxt;
        an      <= w_an;
        Seg     <= {w_dp_n, (w_blank ? 7'h7F : w_seg7)};
        decimal <= w_dp_n;
        if (w_wrap) begin
          for (int unsigned i = 0; i < 4; i++) begin
            r_s[i] <= w_live[i];
          end
        end
      end
    end
  end

endmodule
